// File: rtl/psoc_audio_tdm_tx.sv
// rtl/psoc_audio_tdm_tx.sv - frame FIFO feeding an I2S / TDM serial audio transmitter
module psoc_audio_tdm_tx #(
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_BITS   = 24,
  parameter int SLOT_BITS     = 32,
  parameter int FIFO_LEN_BITS = 8,
  parameter int SCLK_DIV      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            mode,
  input  logic                            underrun_zero,
  input  logic [CHANNELS*SAMPLE_BITS-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FIFO_LEN_BITS:0]          fifo_threshold,
  output logic [FIFO_LEN_BITS:0]          fifo_level,
  output logic                            fifo_low,
  output logic [15:0]                     underrun_count,
  input  logic                            clear_underrun,
  output logic                            sclk,
  output logic                            lrclk,
  output logic                            sdata
);

  localparam int FW     = CHANNELS * SAMPLE_BITS;
  localparam int DEPTH  = 2 ** FIFO_LEN_BITS;
  localparam int SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int POS_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [SLOT_W-1:0]        SLOT_LAST  = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0]        SLOT_HALF  = SLOT_W'(CHANNELS / 2);
  localparam logic [SLOT_W-1:0]        SLOT_ONE   = SLOT_W'(1);
  localparam logic [POS_W-1:0]         POS_LAST   = POS_W'(SLOT_BITS - 1);
  localparam logic [POS_W-1:0]         POS_ONE    = POS_W'(1);
  localparam logic [DIV_W-1:0]         DIV_LAST   = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]         DIV_ONE    = DIV_W'(1);
  localparam logic [FIFO_LEN_BITS-1:0] PTR_ONE    = FIFO_LEN_BITS'(1);
  localparam logic [FIFO_LEN_BITS:0]   LEVEL_ONE  = {{FIFO_LEN_BITS{1'b0}}, 1'b1};
  localparam logic [FIFO_LEN_BITS:0]   LEVEL_FULL = {1'b1, {FIFO_LEN_BITS{1'b0}}};

  // frame storage
  logic [FW-1:0]            fifo_mem [DEPTH];
  logic [FIFO_LEN_BITS-1:0] wr_ptr;
  logic [FIFO_LEN_BITS-1:0] rd_ptr;
  logic [FIFO_LEN_BITS:0]   level;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;

  // serializer state
  logic              active;
  logic              sclk_r;
  logic              lrclk_r;
  logic              sdata_r;
  logic              cur_bit;
  logic              mode_r;
  logic [DIV_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot_idx;
  logic [POS_W-1:0]  pos_idx;
  logic [FW-1:0]     tx_frame;
  logic [FW-1:0]     last_frame;
  logic [15:0]       underrun_cnt;

  // next-state helpers
  logic              div_wrap;
  logic              fall;
  logic              at_last;
  logic              boundary;
  logic              underrun;
  logic [FW-1:0]     load_frame;
  logic [FW-1:0]     use_frame;
  logic              use_mode;
  logic [SLOT_W-1:0] slot_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              bit_nxt;

  // Bit p of slot s: sample s MSB-first, then zero padding to the slot width.
  function automatic logic bit_of(input logic [FW-1:0] f, input logic [SLOT_W-1:0] s,
                                  input logic [POS_W-1:0] p);
    logic [FW-1:0] sh;
    int            idx;
    bit_of = 1'b0;
    if (int'(p) < SAMPLE_BITS) begin
      idx    = int'(s) * SAMPLE_BITS + (SAMPLE_BITS - 1 - int'(p));
      sh     = f >> idx;
      bit_of = sh[0];
    end
  endfunction

  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;

  // Frame boundary detection, frame selection and next bit position
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    fall     = active & div_wrap & sclk_r;
    at_last  = (slot_idx == SLOT_LAST) && (pos_idx == POS_LAST);
    // the first enabled cycle is also a frame boundary
    boundary = enable & (~active | (fall & at_last));
    pop      = boundary & ~empty;
    underrun = boundary & empty;

    if (pop) begin
      load_frame = fifo_mem[rd_ptr];
    end else if (underrun_zero) begin
      load_frame = '0;
    end else begin
      load_frame = last_frame;
    end
    use_frame = boundary ? load_frame : tx_frame;
    use_mode  = boundary ? mode : mode_r;

    if (boundary) begin
      slot_nxt = '0;
      pos_nxt  = '0;
    end else if (pos_idx == POS_LAST) begin
      slot_nxt = slot_idx + SLOT_ONE;
      pos_nxt  = '0;
    end else begin
      slot_nxt = slot_idx;
      pos_nxt  = pos_idx + POS_ONE;
    end
    bit_nxt = bit_of(use_frame, slot_nxt, pos_nxt);
  end

  // FIFO data array (no reset needed on storage)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Last popped frame and saturating underrun counter; clear wins but still counts a same-cycle underrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_frame   <= '0;
      underrun_cnt <= '0;
    end else begin
      if (pop) begin
        last_frame <= load_frame;
      end
      if (clear_underrun) begin
        underrun_cnt <= underrun ? 16'd1 : 16'd0;
      end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

  // Bit clock divider, bit position and serial outputs; outputs only move on sclk falling edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      sclk_r   <= 1'b0;
      slot_idx <= '0;
      pos_idx  <= '0;
      lrclk_r  <= 1'b0;
      sdata_r  <= 1'b0;
      cur_bit  <= 1'b0;
      mode_r   <= 1'b0;
      tx_frame <= '0;
    end else if (!enable) begin
      // stopping discards the rest of the frame in flight
      active   <= 1'b0;
      div_cnt  <= '0;
      sclk_r   <= 1'b0;
      slot_idx <= '0;
      pos_idx  <= '0;
      lrclk_r  <= 1'b0;
      sdata_r  <= 1'b0;
      cur_bit  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (!active) begin
        div_cnt <= '0;
        sclk_r  <= 1'b0;
      end else if (div_wrap) begin
        div_cnt <= '0;
        sclk_r  <= ~sclk_r;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end

      if (boundary) begin
        tx_frame <= load_frame;
        mode_r   <= mode;
      end

      if (boundary || fall) begin
        slot_idx <= slot_nxt;
        pos_idx  <= pos_nxt;
        cur_bit  <= bit_nxt;
        // I2S shifts data one bit late; cur_bit still holds the previous bit here
        sdata_r  <= use_mode ? bit_nxt : cur_bit;
        lrclk_r  <= use_mode ? ((slot_nxt == '0) && (pos_nxt == '0))
                             : (slot_nxt >= SLOT_HALF);
      end
    end
  end

  assign fifo_level     = level;
  assign fifo_low       = (level < fifo_threshold);
  assign underrun_count = underrun_cnt;
  assign sclk           = sclk_r;
  assign lrclk          = lrclk_r;
  assign sdata          = sdata_r;

endmodule

// File: tb/tb_psoc_audio_tdm_tx.sv
// tb/tb_psoc_audio_tdm_tx.sv - table-driven and randomized checks against a frame-level model
module tb_psoc_audio_tdm_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0, mode = 1'b0, uz = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [47:0] din_a = '0;
  logic [95:0] din_b = '0;
  logic        val_a = 1'b0, val_b = 1'b0, rdy_a, rdy_b;
  logic [8:0]  thr_a = '0, lvl_a;
  logic [3:0]  thr_b = '0, lvl_b;
  logic        low_a, low_b;
  logic [15:0] cnt_a, cnt_b;
  logic        sclk_a, lr_a, sd_a, sclk_b, lr_b, sd_b;

  psoc_audio_tdm_tx dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .mode(mode), .underrun_zero(uz),
    .in_data(din_a), .in_valid(val_a), .in_ready(rdy_a), .fifo_threshold(thr_a),
    .fifo_level(lvl_a), .fifo_low(low_a), .underrun_count(cnt_a), .clear_underrun(clr_a),
    .sclk(sclk_a), .lrclk(lr_a), .sdata(sd_a)
  );

  psoc_audio_tdm_tx #(.CHANNELS(4), .SAMPLE_BITS(24), .SLOT_BITS(32), .FIFO_LEN_BITS(3),
                      .SCLK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(mode), .underrun_zero(uz),
    .in_data(din_b), .in_valid(val_b), .in_ready(rdy_b), .fifo_threshold(thr_b),
    .fifo_level(lvl_b), .fifo_low(low_b), .underrun_count(cnt_b), .clear_underrun(clr_b),
    .sclk(sclk_b), .lrclk(lr_b), .sdata(sd_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model: frame queues, last frame, underrun counters
  logic [95:0] mq_a[$];
  logic [95:0] mq_b[$];
  logic [95:0] m_last_a = '0, m_last_b = '0;
  logic [15:0] m_cnt_a = '0, m_cnt_b = '0;

  function automatic int msize(input int sel);
    return sel ? mq_b.size() : mq_a.size();
  endfunction

  task automatic model_reset();
    mq_a.delete(); mq_b.delete();
    m_last_a = '0; m_last_b = '0;
    m_cnt_a = '0;  m_cnt_b = '0;
  endtask

  // sclk rising-edge capture, sampled on the clk falling edge after sclk goes high
  logic cap_la[$], cap_da[$], cap_lb[$], cap_db[$];
  logic ps_a = 1'b0, ps_b = 1'b0;
  always @(negedge clk) begin
    if (sclk_a && !ps_a) begin cap_la.push_back(lr_a); cap_da.push_back(sd_a); end
    if (sclk_b && !ps_b) begin cap_lb.push_back(lr_b); cap_db.push_back(sd_b); end
    ps_a = sclk_a;
    ps_b = sclk_b;
  end

  // per-frame schedules consumed by run()
  logic sch_md[8], sch_uz[8], sch_clr[8];

  task automatic push(input int sel, input logic [95:0] d);
    if (sel != 0) begin
      val_b = 1'b1; din_b = d;
      if (mq_b.size() < 8) mq_b.push_back(d);
    end else begin
      val_a = 1'b1; din_a = d[47:0];
      if (mq_a.size() < 256) mq_a.push_back({48'b0, d[47:0]});
    end
    @(negedge clk);
    val_a = 1'b0; val_b = 1'b0;
  endtask

  // Runs k frames on one DUT (called at a clk falling edge) and compares the captured stream.
  task automatic run(input int sel, input int k);
    int          ch = (sel != 0) ? 4 : 2;
    int          nb = ch * 32;
    int          per = nb * 4;
    logic [95:0] tf[8];
    logic [95:0] fr;
    logic        carry, raw, ur;
    logic [127:0] el, ed, al, ad;
    int          c, kk;
    cap_la.delete(); cap_da.delete(); cap_lb.delete(); cap_db.delete();
    for (int f = 0; f < k; f++) begin
      mode = sch_md[f]; uz = sch_uz[f];
      if (sel != 0) begin en_b = 1'b1; clr_b = sch_clr[f]; end
      else begin en_a = 1'b1; clr_a = sch_clr[f]; end
      ur = (msize(sel) == 0);
      if (sel != 0) begin
        if (!ur) begin tf[f] = mq_b.pop_front(); m_last_b = tf[f]; end
        else tf[f] = sch_uz[f] ? 96'b0 : m_last_b;
        if (sch_clr[f]) m_cnt_b = ur ? 16'd1 : 16'd0;
        else if (ur && m_cnt_b != 16'hFFFF) m_cnt_b = m_cnt_b + 16'd1;
      end else begin
        if (!ur) begin tf[f] = mq_a.pop_front(); m_last_a = tf[f]; end
        else tf[f] = sch_uz[f] ? 96'b0 : m_last_a;
        if (sch_clr[f]) m_cnt_a = ur ? 16'd1 : 16'd0;
        else if (ur && m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
      end
      @(negedge clk);
      clr_a = 1'b0; clr_b = 1'b0;
      chk($sformatf("s%0d_f%0d_level", sel, f), (sel != 0) ? 128'(lvl_b) : 128'(lvl_a),
          128'(msize(sel)));
      chk($sformatf("s%0d_f%0d_underrun", sel, f), (sel != 0) ? 128'(cnt_b) : 128'(cnt_a),
          (sel != 0) ? 128'(m_cnt_b) : 128'(m_cnt_a));
      repeat (per - 1) @(negedge clk);
    end
    en_a = 1'b0; en_b = 1'b0;
    chk($sformatf("s%0d_capture_len", sel),
        (sel != 0) ? 128'(cap_lb.size()) : 128'(cap_la.size()), 128'(k * nb));
    carry = 1'b0;
    for (int f = 0; f < k; f++) begin
      el = '0; ed = '0; al = '0; ad = '0;
      fr = tf[f];
      for (int b = 0; b < nb; b++) begin
        c  = b / 32;
        kk = b % 32;
        raw = (kk < 24) ? fr[c * 24 + 23 - kk] : 1'b0;
        if (sch_md[f]) begin ed[b] = raw;   el[b] = (b == 0); end
        else           begin ed[b] = carry; el[b] = (c >= ch / 2); end
        carry = raw;
        if (sel != 0) begin
          if (cap_lb.size() > 0) begin al[b] = cap_lb.pop_front(); ad[b] = cap_db.pop_front(); end
        end else begin
          if (cap_la.size() > 0) begin al[b] = cap_la.pop_front(); ad[b] = cap_da.pop_front(); end
        end
      end
      chk($sformatf("s%0d_f%0d_lrclk", sel, f), al, el);
      chk($sformatf("s%0d_f%0d_sdata", sel, f), ad, ed);
    end
  endtask

  typedef struct {
    int         n_push;
    logic [8:0] thr;
    logic [8:0] exp_level;
    logic       exp_low;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 9'd0,   9'd0, 1'b0};
    vecs[1] = '{0, 9'd1,   9'd0, 1'b1};
    vecs[2] = '{3, 9'd4,   9'd3, 1'b1};
    vecs[3] = '{1, 9'd4,   9'd4, 1'b0};
    vecs[4] = '{0, 9'd0,   9'd4, 1'b0};
    vecs[5] = '{2, 9'd5,   9'd6, 1'b0};
    vecs[6] = '{0, 9'd7,   9'd6, 1'b1};
    vecs[7] = '{0, 9'h100, 9'd6, 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // reset state
    chk("rst_level", 128'(lvl_a), 128'd0);
    chk("rst_ready", 128'(rdy_a), 128'd1);
    chk("rst_underrun", 128'(cnt_a), 128'd0);
    chk("rst_pins", 128'({sclk_a, lr_a, sd_a}), 128'd0);
    chk("rst_low_thr0", 128'(low_a), 128'd0);
    chk("rst_level_b", 128'(lvl_b), 128'd0);

    // one stereo I2S frame: L=ABCDEF, R=123456
    push(0, {48'b0, 24'h123456, 24'hABCDEF});
    chk("t1_level_before", 128'(lvl_a), 128'd1);
    sch_md[0] = 1'b0; sch_uz[0] = 1'b0; sch_clr[0] = 1'b0;
    run(0, 1);

    // FIFO level / watermark table
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < vecs[i].n_push; p++) push(0, {$urandom, $urandom, $urandom});
      thr_a = vecs[i].thr;
      #1;
      chk($sformatf("tab%0d_level", i), 128'(lvl_a), 128'(vecs[i].exp_level));
      chk($sformatf("tab%0d_low", i), 128'(low_a), 128'(vecs[i].exp_low));
      chk($sformatf("tab%0d_ready", i), 128'(rdy_a), 128'd1);
    end
    thr_a = '0;
    @(negedge clk);

    // random modes and policies, drains the 6 queued frames then underruns
    for (int f = 0; f < 8; f++) begin
      sch_md[f] = 1'($urandom); sch_uz[f] = 1'($urandom); sch_clr[f] = ($urandom_range(3) == 0);
    end
    run(0, 8);

    // repeat-last then zero-fill underruns
    push(0, {48'b0, 24'h800000, 24'h000001});
    for (int f = 0; f < 5; f++) begin sch_md[f] = 1'b0; sch_uz[f] = (f == 4); sch_clr[f] = 1'b0; end
    run(0, 5);

    // saturation near 16'hFFFF and clear on an underrun cycle
    force dut_a.underrun_cnt = 16'hFFFE;
    @(negedge clk);
    release dut_a.underrun_cnt;
    @(negedge clk);
    m_cnt_a = 16'hFFFE;
    chk("sat_preset", 128'(cnt_a), 128'(16'hFFFE));
    for (int f = 0; f < 3; f++) begin sch_md[f] = 1'b0; sch_uz[f] = 1'b1; sch_clr[f] = (f == 2); end
    run(0, 3);

    // fill to full, hold in_valid, then one boundary pop
    for (int i = 0; i < 256; i++) push(0, {$urandom, $urandom, $urandom});
    chk("full_level", 128'(lvl_a), 128'h100);
    chk("full_ready", 128'(rdy_a), 128'd0);
    val_a = 1'b1; din_a = {$urandom, $urandom};
    repeat (5) @(negedge clk);
    chk("full_hold_level", 128'(lvl_a), 128'h100);
    mode = 1'b0; uz = 1'b0; en_a = 1'b1;
    @(negedge clk);
    val_a = 1'b0;
    void'(mq_a.pop_front());
    chk("full_pop_level", 128'(lvl_a), 128'd255);
    chk("full_pop_ready", 128'(rdy_a), 128'd1);

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 20 && !sclk_a; i++) @(negedge clk);
    chk("pre_reset_sclk_high", 128'(sclk_a), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pins", 128'({sclk_a, lr_a, sd_a}), 128'd0);
    chk("async_rst_level", 128'(lvl_a), 128'd0);
    chk("async_rst_ready", 128'(rdy_a), 128'd1);
    @(negedge clk);
    en_a = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // 4-channel TDM: frames 1..4, no underrun
    for (int n = 1; n <= 4; n++)
      push(1, {8'(n), 8'd3, 8'($urandom), 8'(n), 8'd2, 8'($urandom),
               8'(n), 8'd1, 8'($urandom), 8'(n), 8'd0, 8'($urandom)});
    for (int f = 0; f < 4; f++) begin sch_md[f] = 1'b1; sch_uz[f] = 1'b0; sch_clr[f] = 1'b0; end
    run(1, 4);
    chk("tdm_no_underrun", 128'(cnt_b), 128'd0);

    // 4-channel random mode mix with underrun
    push(1, {$urandom, $urandom, $urandom});
    push(1, {$urandom, $urandom, $urandom});
    for (int f = 0; f < 3; f++) begin
      sch_md[f] = 1'($urandom); sch_uz[f] = 1'($urandom); sch_clr[f] = 1'b0;
    end
    run(1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
